adder_block_accumulator: RTL

Downstream consumer of the 8-bit three-operand adder stage. It takes each adder result, `{c_out, r}` as a 9-bit value, through a valid/ready handshake. It sums a block of `BLOCK_LEN` results, or fewer if flushed early, into a wide accumulator. It then presents the block sum, beat count and overflow flag on a held output handshake.

---
 rtl/adder_pkg.sv | 27 ++
 rtl/adder_block_accumulator.sv | 112 +++++++++++
 2 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the three-operand adder stage and its downstream consumers:
// accumulator state type, default widths and the {carry, r} sample packing.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } acc_state_t;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ACC_W  = 16;

    // Widest supported sample/accumulator; callers cast down to their own width.
    localparam int unsigned MAX_DATA_W = 63;
    localparam int unsigned MAX_ACC_W  = 64;

    // Places the adder carry directly above the data_w sum bits, zero-extended.
    function automatic logic [MAX_ACC_W-1:0] pack_sample(
        input logic                  carry,
        input logic [MAX_DATA_W-1:0] r,
        input int unsigned           data_w
    );
        return MAX_ACC_W'(r) | (MAX_ACC_W'(carry) << data_w);
    endfunction

endpackage

// File: rtl/adder_block_accumulator.sv
// Sums blocks of BLOCK_LEN adder results (or fewer when flushed) and presents the
// block sum, beat count and sticky overflow flag on a held output handshake.
module adder_block_accumulator
    import adder_pkg::*;
#(
    parameter  int unsigned DATA_W    = DEF_DATA_W,
    parameter  int unsigned ACC_W     = DEF_ACC_W,
    parameter  int unsigned BLOCK_LEN = 4,
    localparam int unsigned CNT_W     = $clog2(BLOCK_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic              in_carry,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    if (ACC_W < DATA_W + 1 || ACC_W > MAX_ACC_W || DATA_W > MAX_DATA_W) begin : g_bad_width
        $error("adder_block_accumulator: ACC_W must cover DATA_W+1 and stay within package limits");
    end
    if (BLOCK_LEN < 1) begin : g_bad_block_len
        $error("adder_block_accumulator: BLOCK_LEN must be at least 1");
    end

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sample;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic             last_beat;

    assign in_ready  = (state_q != DONE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

    assign sample = ACC_W'(pack_sample(in_carry, MAX_DATA_W'(in_r), DATA_W));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        accept    = in_valid && in_ready;
        sum_ext   = {1'b0, acc_q} + {1'b0, sample};
        cnt_inc   = cnt_q + CNT_W'(1);
        // Count is zero in IDLE, so this also covers BLOCK_LEN == 1 on the first beat.
        last_beat = (cnt_inc == CNT_W'(BLOCK_LEN));

        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = sample;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (last_beat || flush) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = sum_ext[ACC_W-1:0];
                    ovf_d = ovf_q | sum_ext[ACC_W];
                    cnt_d = cnt_inc;
                    if (last_beat || flush) begin
                        state_d = DONE;
                    end
                end else if (flush) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
